// File: rtl/gemm_acc_buf.sv
// Accumulation buffer behind the GEMM post-processor ACC read port: 2-stage
// read-modify-write write path, 1-cycle read port, and a whole-array clear engine.
module gemm_acc_buf #(
   parameter int DEPTH = 256,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [15:0]      wr_addr,
   input  logic [ACC_W-1:0] wr_data,
   input  logic             wr_accum,
   input  logic             wr_last,
   input  logic             clr_valid,
   output logic             clr_ready,
   input  logic             acc_rd_en,
   input  logic [15:0]      acc_rd_addr,
   output logic [ACC_W-1:0] acc_rd_data,
   output logic             acc_rd_valid,
   output logic             tile_done,
   output logic             clr_done,
   output logic             busy,
   output logic             sat_flag,
   output logic             oob_flag
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0]      DEPTH_L  = 17'(DEPTH);
   localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
   localparam logic [ACC_W-1:0] MAX_V    = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V    = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      CLEAR
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     clr_cnt_q;
   logic              clr_cmd_q;

   logic              s1_valid_q;
   logic [15:0]       s1_addr_q;
   logic [ACC_W-1:0]  s1_data_q;
   logic              s1_accum_q;
   logic              s1_last_q;
   logic [ACC_W-1:0]  mem_q;

   logic              fwd_valid_q;
   logic [15:0]       fwd_addr_q;
   logic [ACC_W-1:0]  fwd_data_q;

   logic [ACC_W-1:0]  mem [DEPTH];

   logic              wr_accept, clr_accept;
   logic              s1_in_range, rd_in_range;
   logic              commit, sat_hit, clear_last;
   logic [ACC_W-1:0]  old_val, add_val, new_val, rd_val;
   logic [ACC_W:0]    sum_ext;
   logic              sum_ovf;
   logic [AW-1:0]     rd_idx;

   assign wr_ready   = !rst && (state_q == RUN);
   assign clr_ready  = !rst && (state_q == RUN);
   assign wr_accept  = wr_valid && wr_ready;
   assign clr_accept = clr_valid && clr_ready;
   assign busy       = rst || (state_q != RUN) || s1_valid_q;
   assign clear_last = (state_q == CLEAR) && (clr_cnt_q == LAST_IDX);

   assign s1_in_range = {1'b0, s1_addr_q} < DEPTH_L;
   assign rd_in_range = {1'b0, acc_rd_addr} < DEPTH_L;
   assign rd_idx      = acc_rd_addr[AW-1:0];

   // Stage 2: the forward register covers the op that committed on the edge the array read sampled
   always_comb begin
      old_val = mem_q;
      if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
         old_val = fwd_data_q;
      end
      sum_ext = {old_val[ACC_W-1], old_val} + {s1_data_q[ACC_W-1], s1_data_q};
      sum_ovf = sum_ext[ACC_W] != sum_ext[ACC_W-1];
      add_val = sum_ext[ACC_W-1:0];
      if (sum_ovf) begin
         add_val = sum_ext[ACC_W] ? MIN_V : MAX_V;
      end
      new_val = s1_accum_q ? add_val : s1_data_q;
      commit  = s1_valid_q && s1_in_range && !rst;
      sat_hit = commit && s1_accum_q && sum_ovf;
   end

   // Read response: out-of-range and the entry being cleared read as zero, else write-first bypass
   always_comb begin
      rd_val = mem[rd_idx];
      if (!rd_in_range) begin
         rd_val = '0;
      end else if ((state_q == CLEAR) && (rd_idx == clr_cnt_q)) begin
         rd_val = '0;
      end else if (commit && (s1_addr_q == acc_rd_addr)) begin
         rd_val = new_val;
      end
   end

   // Next-state logic; a write accepted alongside a clear must drain before clearing
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (clr_accept) begin
               state_d = (s1_valid_q || wr_accept) ? DRAIN : CLEAR;
            end
         end
         DRAIN: begin
            state_d = CLEAR;
         end
         CLEAR: begin
            if (clr_cnt_q == LAST_IDX) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR;
         clr_cnt_q    <= '0;
         clr_cmd_q    <= 1'b0;
         s1_valid_q   <= 1'b0;
         fwd_valid_q  <= 1'b0;
         tile_done    <= 1'b0;
         clr_done     <= 1'b0;
         sat_flag     <= 1'b0;
         oob_flag     <= 1'b0;
         acc_rd_valid <= 1'b0;
         acc_rd_data  <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= (state_q == CLEAR) ? clr_cnt_q + AW'(1) : '0;
         s1_valid_q   <= wr_accept;
         fwd_valid_q  <= commit;
         tile_done    <= s1_valid_q && s1_last_q;
         clr_done     <= clear_last && clr_cmd_q;
         acc_rd_valid <= acc_rd_en;
         if (clr_accept) begin
            clr_cmd_q <= 1'b1;
         end else if (clear_last) begin
            clr_cmd_q <= 1'b0;
         end
         sat_flag <= clr_accept ? 1'b0 : (sat_flag | sat_hit);
         oob_flag <= clr_accept ? 1'b0 : (oob_flag | (s1_valid_q && !s1_in_range));
         if (acc_rd_en) begin
            acc_rd_data <= rd_val;
         end
      end
   end

   // Stage 1 registers and the forward register carry no control meaning, so no reset
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         s1_addr_q  <= wr_addr;
         s1_data_q  <= wr_data;
         s1_accum_q <= wr_accum;
         s1_last_q  <= wr_last;
      end
      if (commit) begin
         fwd_addr_q <= s1_addr_q;
         fwd_data_q <= new_val;
      end
   end

   // Array: synchronous read for stage 1, one write port shared by clear and commit
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q <= mem[wr_addr[AW-1:0]];
      end
      if (state_q == CLEAR) begin
         mem[clr_cnt_q] <= '0;
      end else if (commit) begin
         mem[s1_addr_q[AW-1:0]] <= new_val;
      end
   end

endmodule

// File: tb/tb_gemm_acc_buf.sv
// Directed bench for gemm_acc_buf: read responses go through an expected-value
// queue checked by a monitor; flags and pulses are checked inline.
module tb_gemm_acc_buf;

   localparam int DEPTH = 256;
   localparam int ACC_W = 32;

   logic             clk;
   logic             rst;
   logic             wr_valid;
   logic             wr_ready;
   logic [15:0]      wr_addr;
   logic [ACC_W-1:0] wr_data;
   logic             wr_accum;
   logic             wr_last;
   logic             clr_valid;
   logic             clr_ready;
   logic             acc_rd_en;
   logic [15:0]      acc_rd_addr;
   logic [ACC_W-1:0] acc_rd_data;
   logic             acc_rd_valid;
   logic             tile_done;
   logic             clr_done;
   logic             busy;
   logic             sat_flag;
   logic             oob_flag;

   gemm_acc_buf #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_accum(wr_accum), .wr_last(wr_last),
      .clr_valid(clr_valid), .clr_ready(clr_ready),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
      .acc_rd_data(acc_rd_data), .acc_rd_valid(acc_rd_valid),
      .tile_done(tile_done), .clr_done(clr_done), .busy(busy),
      .sat_flag(sat_flag), .oob_flag(oob_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   int          clr_done_cnt = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_addr_q[$];
   logic [31:0] mon_exp;
   logic [15:0] mon_addr;

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      wr_valid  = 1'b0;
      wr_last   = 1'b0;
      clr_valid = 1'b0;
      acc_rd_en = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [15:0] a, input logic [31:0] d, input logic acc,
                                 input logic last);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_accum = acc;
      wr_last  = last;
   endtask

   task automatic issue_read(input logic [15:0] a, input logic [31:0] e);
      acc_rd_en   = 1'b1;
      acc_rd_addr = a;
      exp_q.push_back(e);
      exp_addr_q.push_back(a);
   endtask

   // Read-response monitor, decoupled from stimulus
   always @(negedge clk) begin
      if (acc_rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL rd_unexpected: got valid with data %h, expected no response", acc_rd_data);
         end else begin
            mon_exp  = exp_q.pop_front();
            mon_addr = exp_addr_q.pop_front();
            check_output($sformatf("rd_data[%0d]", mon_addr), acc_rd_data, mon_exp);
         end
      end
      if (clr_done === 1'b1) clr_done_cnt++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int ready_err;
      rst = 1'b1;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_accum = 1'b0; wr_last = 1'b0;
      clr_valid = 1'b0; acc_rd_en = 1'b0; acc_rd_addr = '0;

      repeat (3) tick();
      @(negedge clk);
      check_output("rst_busy", busy, 1);
      check_output("rst_wr_ready", wr_ready, 0);
      check_output("rst_clr_ready", clr_ready, 0);
      check_output("rst_rd_valid", acc_rd_valid, 0);
      check_output("rst_tile_done", tile_done, 0);
      check_output("rst_sat_flag", sat_flag, 0);
      check_output("rst_oob_flag", oob_flag, 0);
      tick();
      rst = 1'b0;

      n = 0;
      while (wr_ready !== 1'b1 && n < 2 * DEPTH) begin
         tick();
         n++;
      end
      check_output("reset_clear_cycles", n, DEPTH);
      @(negedge clk);
      check_output("idle_busy", busy, 0);
      issue_read(16'd0, 32'd0);   tick();
      issue_read(16'd100, 32'd0); tick();
      issue_read(16'd255, 32'd0); tick();
      tick(); tick();
      check_output("no_clr_done_after_reset", clr_done_cnt, 0);

      // Overwrite then accumulate on consecutive cycles, with a bypassed read in between
      apply_stimulus(16'd3, 32'd5, 1'b0, 1'b0); tick();
      apply_stimulus(16'd3, 32'd7, 1'b1, 1'b0); issue_read(16'd3, 32'd5); tick();
      issue_read(16'd3, 32'd12); tick();
      tick(); tick();

      // Sixteen back-to-back accumulates exercise the forward register
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(16'd9, 32'd1, 1'b1, (i == 15));
         tick();
      end
      @(negedge clk);
      check_output("burst_tile_done_early", tile_done, 0);
      check_output("burst_busy", busy, 1);
      tick();
      @(negedge clk);
      check_output("burst_tile_done", tile_done, 1);
      issue_read(16'd9, 32'd16);
      tick();
      @(negedge clk);
      check_output("burst_tile_done_width", tile_done, 0);
      check_output("burst_idle_busy", busy, 0);
      tick();

      apply_stimulus(16'd9, 32'd100, 1'b1, 1'b0); tick();
      tick(); tick();
      issue_read(16'd9, 32'd116); tick();
      tick();

      // Saturation at both ends of the signed range
      @(negedge clk);
      check_output("sat_flag_before", sat_flag, 0);
      tick();
      apply_stimulus(16'd0, 32'h7FFF_FFF0, 1'b0, 1'b0); tick();
      apply_stimulus(16'd0, 32'h0000_0020, 1'b1, 1'b0); tick();
      apply_stimulus(16'd1, 32'h8000_0000, 1'b0, 1'b0); tick();
      apply_stimulus(16'd1, 32'hFFFF_FFFF, 1'b1, 1'b0); tick();
      tick(); tick();
      @(negedge clk);
      check_output("sat_flag_set", sat_flag, 1);
      check_output("oob_flag_before", oob_flag, 0);
      issue_read(16'd0, 32'h7FFF_FFFF); tick();
      issue_read(16'd1, 32'h8000_0000); tick();
      tick();

      // Out-of-range write: flag and tile_done, but no entry touched
      apply_stimulus(16'd300, 32'h0000_1234, 1'b0, 1'b1); tick();
      @(negedge clk);
      check_output("oob_tile_done_early", tile_done, 0);
      tick();
      @(negedge clk);
      check_output("oob_tile_done", tile_done, 1);
      check_output("oob_flag_set", oob_flag, 1);
      issue_read(16'd300, 32'd0); tick();
      issue_read(16'd44, 32'd0);  tick();
      tick();

      // Write and clear in the same cycle
      apply_stimulus(16'd5, 32'd55, 1'b0, 1'b0);
      clr_valid = 1'b1;
      @(negedge clk);
      check_output("coll_wr_ready", wr_ready, 1);
      check_output("coll_clr_ready", clr_ready, 1);
      tick();
      @(negedge clk);
      check_output("drain_wr_ready", wr_ready, 0);
      check_output("drain_clr_ready", clr_ready, 0);
      check_output("drain_busy", busy, 1);
      check_output("drain_sat_flag", sat_flag, 0);
      check_output("drain_oob_flag", oob_flag, 0);
      issue_read(16'd5, 32'd55);
      tick();
      issue_read(16'd0, 32'd0);   tick();
      issue_read(16'd9, 32'd116); tick();

      n = 0;
      ready_err = 0;
      while (n < 2 * DEPTH) begin
         @(negedge clk);
         if (clr_done === 1'b1) break;
         if (wr_ready !== 1'b0) ready_err++;
         tick();
         n++;
      end
      check_output("clear_cycles", n, 254);
      check_output("clear_wr_ready_low", ready_err, 0);
      check_output("clear_done_wr_ready", wr_ready, 1);
      tick();
      @(negedge clk);
      check_output("clr_done_width", clr_done, 0);
      issue_read(16'd5, 32'd0); tick();
      issue_read(16'd9, 32'd0); tick();
      issue_read(16'd0, 32'd0); tick();
      issue_read(16'd1, 32'd0); tick();
      issue_read(16'd3, 32'd0); tick();
      tick(); tick();
      check_output("clr_done_count", clr_done_cnt, 1);
      check_output("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gemm_acc_buf.md
# gemm_acc_buf

Accumulation buffer that sits on the other end of the GEMM post-processor's ACC SRAM read port. It has three jobs:
- Absorb systolic-array partial sums through a write port with a 2-stage read-modify-write pipeline. Each write either overwrites an entry or saturating-adds to it, at one write per cycle.
- Serve `acc_rd_en`/`acc_rd_addr` requests with fixed 1-cycle latency and `acc_rd_valid`.
- Clear the whole array, both on reset and on command.

## Interface
- `DEPTH`, 256: number of ACC_W entries; valid addresses are 0..DEPTH-1.
- `ACC_W`, 32: accumulator width, signed.

Ports (clock and reset first):
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  partial-sum write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  16  target entry.
- `wr_data`  in  ACC_W  signed partial sum.
- `wr_accum`  in  1  1 = saturating add to the entry; 0 = overwrite.
- `wr_last`  in  1  marks the final write of a tile.
- `clr_valid`  in  1  request a full clear.
- `clr_ready`  out  1  clear request accepted when `clr_valid && clr_ready`.
- `acc_rd_en`  in  1  read request.
- `acc_rd_addr`  in  16  read address.
- `acc_rd_data`  out  ACC_W  read data.
- `acc_rd_valid`  out  1  read response strobe.
- `tile_done`  out  1  one-cycle pulse after the `wr_last` write commits.
- `clr_done`  out  1  one-cycle pulse when a clear completes.
- `busy`  out  1  FSM not in RUN, or RMW pipeline non-empty.
- `sat_flag`  out  1  sticky: an accumulate saturated.
- `oob_flag`  out  1  sticky: a write address was >= DEPTH.

## Operation
- **FSM states:** RUN, DRAIN, CLEAR.
  - While `rst` is high, the next state is CLEAR with the clear counter at 0.
  - RUN: `wr_ready = 1` and `clr_ready = 1`. An accepted clear goes to DRAIN if the RMW pipeline holds a valid op, otherwise directly to CLEAR.
  - DRAIN: `wr_ready = 0` and `clr_ready = 0`. Go to CLEAR once the in-flight op has committed.
  - CLEAR: write 0 to entry `clr_cnt` on each cycle, `clr_cnt` from 0 to DEPTH-1. After entry DEPTH-1, go to RUN and pulse `clr_done`.
- **Clear flags:** an accepted clear and a reset both clear `sat_flag` and `oob_flag`.
- **Simultaneous write and clear in RUN:** if `wr_valid` and `clr_valid` are both high, the write is accepted and completes before the clear starts.
- **RMW pipeline:**
  - Stage 1 (accept cycle t): register addr, data, accum and last; issue the array read of `wr_addr`.
  - Stage 2 (cycle t+1): take the old value. Use the forward register if its address equals the stage-2 address (i.e. the previous op committed in cycle t), otherwise use the array output.
    - `new = accum ? sat_add(old, data) : data`.
    - The array and the forward register {addr, new} are written on the edge ending t+1.
- **Saturating add:** the sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Clamping sets `sat_flag`. Overwrite never saturates.
- **Out-of-range write (addr >= DEPTH):** the op flows through the pipeline but makes no array write and no forward update. It sets `oob_flag`. `wr_last` on such an op still pulses `tile_done`.
- **Read port:** dual-ported against the RMW pipeline and never stalls writes.
  - A read in cycle t returns the array contents, write-first bypassed: if stage 2 commits to the same address in cycle t, the committed value is returned.
  - During CLEAR, a read of entry `clr_cnt` returns 0; other entries return their current contents.
  - A read with addr >= DEPTH returns 0 with valid.

## Timing
- **Reset values:** while `rst` is high all registered outputs are 0, `wr_ready`/`clr_ready` are 0, and `busy` is 1.
  - The first RUN cycle is DEPTH+1 cycles after `rst` falls: DEPTH cycles of CLEAR, then RUN.
  - Asserting `rst` mid-operation discards any in-flight write and restarts the clear from entry 0.
- **Read latency:** `acc_rd_en` in cycle t gives `acc_rd_valid = 1` and `acc_rd_data` in cycle t+1, for exactly one cycle. Back-to-back reads are allowed every cycle.
- **Write latency:** a write accepted in cycle t commits at the end of t+1.
  - It is visible to a read issued in t+1 (via bypass) or later.
  - It is visible to a write accepted in t+1 (via forward).
  - `tile_done` is high in cycle t+2.
- **Write throughput:** one per cycle, including repeated accumulation to the same address.
- **`clr_done`:** high in the first RUN cycle after CLEAR. There is no `clr_done` after the reset-initiated clear.

## Test plan
- **Reset clear:** pulse `rst`, wait DEPTH+1 cycles, read addresses 0, 100, 255 -> data 0 with valid one cycle later; `busy` 0; `clr_done` never pulses.
- **Overwrite then accumulate:** write 5 to addr 3 (`wr_accum=0`), then 7 to addr 3 (`wr_accum=1`) on consecutive cycles -> a read at t+2 returns 12.
- **Forwarding burst:** write +1 with accumulate to addr 9 on 16 back-to-back cycles, the last with `wr_last` -> `tile_done` 2 cycles after the last accept; a read of addr 9 returns 16.
- **Saturation:** write 0x7FFFFFF0 to addr 0, then accumulate 0x20 -> entry is 0x7FFFFFFF and `sat_flag` goes to 1. Accumulate -1 to addr 1 after a 0x80000000 overwrite -> entry stays 0x80000000.
- **Out of range:** write to addr 300 with DEPTH=256 -> `oob_flag` 1, no entry changes; a read of addr 300 returns 0 with valid.
- **Clear collision:** `wr_valid` and `clr_valid` in the same cycle -> the write commits, the FSM passes through DRAIN, and all entries are 0 after `clr_done`. Flags are cleared, and `wr_ready` is 0 until RUN.
